seg_display_scan: RTL and testbench

Four-digit seven-segment scan driver for the stopwatch/clock design. It consumes the display and blink square waves from the team's clock divider and the current minutes/seconds values. It time-multiplexes the four digits as MM.SS and blanks the field being adjusted at the blink rate. All logic runs in the `clk` domain; the divider outputs are treated as asynchronous levels and synchronized internally.

---
 rtl/seg_display_scan.sv | 120 ++++++++++++
 tb/tb_seg_display_scan.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// Four-digit MM.SS seven-segment scan driver: synchronizes divider square waves,
// steps one digit per scan transition, and blanks the adjusted field at the blink rate.
module seg_display_scan #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_tgl,
    input  logic       blink_tgl,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    logic       s1, s2, s3;
    logic       b1, b2;
    logic       scan_pulse;
    logic       blink_on;
    logic [1:0] idx;
    logic       valid;
    logic [5:0] shadow_min;
    logic [5:0] shadow_sec;
    logic [5:0] field;
    logic [2:0] tens;
    logic [3:0] ones;
    logic [3:0] digit;
    logic       blank;

    function automatic logic [5:0] clamp59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    // Constant divide by ten over the 0-59 range only.
    function automatic logic [2:0] tens_of(input logic [5:0] v);
        if (v >= 6'd50) return 3'd5;
        if (v >= 6'd40) return 3'd4;
        if (v >= 6'd30) return 3'd3;
        if (v >= 6'd20) return 3'd2;
        if (v >= 6'd10) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v, input logic [2:0] t);
        return 4'(v - ({t, 3'b000} + {2'b00, t, 1'b0}));
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign scan_pulse = s2 ^ s3;
    assign blink_on   = b2;

    // Synchronizers, scan index and frame-start shadow capture
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            b1         <= 1'b0;
            b2         <= 1'b0;
            idx        <= 2'd3;
            valid      <= 1'b0;
            shadow_min <= 6'd0;
            shadow_sec <= 6'd0;
        end else begin
            s1 <= scan_tgl;
            s2 <= s1;
            s3 <= s2;
            b1 <= blink_tgl;
            b2 <= b1;
            if (scan_pulse) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    shadow_min <= clamp59(minutes);
                    shadow_sec <= clamp59(seconds);
                    valid      <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        field = idx[1] ? shadow_min : shadow_sec;
        tens  = tens_of(field);
        ones  = ones_of(field, tens);
        digit = idx[0] ? {1'b0, tens} : ones;
        blank = adj && blink_on && (idx[1] != sel);
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst || !valid) begin
            an  <= {4{ACTIVE_LOW}};
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
        end else begin
            an  <= (4'b0001 << idx) ^ {4{ACTIVE_LOW}};
            seg <= (blank ? 7'h00 : seg_decode(digit)) ^ {7{ACTIVE_LOW}};
            dp  <= (idx == 2'd2) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan against a frame-level reference model.
module tb_seg_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_tgl;
    logic       blink_tgl;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adj;
    logic       sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    // Reference model state: which digit is on, whether a frame has started, latched values
    int m_idx   = 3;
    int m_valid = 0;
    int m_min   = 0;
    int m_sec   = 0;

    localparam logic [11:0] OFF = 12'hFFF;
    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    seg_display_scan dut (
        .clk       (clk),
        .rst       (rst),
        .scan_tgl  (scan_tgl),
        .blink_tgl (blink_tgl),
        .minutes   (minutes),
        .seconds   (seconds),
        .adj       (adj),
        .sel       (sel),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    function automatic int clamp(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    // Expected {an, seg, dp} on the board (active-low) pins.
    function automatic logic [11:0] model_out();
        int         f, d;
        logic [3:0] a;
        logic [6:0] s;
        logic       p, blank;
        if (m_valid == 0) return OFF;
        f     = (m_idx >= 2) ? m_min : m_sec;
        d     = (m_idx % 2 == 0) ? (f % 10) : (f / 10);
        blank = adj && blink_tgl && ((sel == 1'b0 && m_idx >= 2) || (sel == 1'b1 && m_idx < 2));
        a     = 4'(1 << m_idx);
        s     = blank ? 7'h00 : seg_tbl[d];
        p     = (m_idx == 2);
        return ~{a, s, p};
    endfunction

    task automatic toggle(input int gap);
        @(negedge clk);
        scan_tgl = ~scan_tgl;
        m_idx = (m_idx + 1) % 4;
        if (m_idx == 0) begin
            m_min   = clamp(int'(minutes));
            m_sec   = clamp(int'(seconds));
            m_valid = 1;
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] got;
        int          bad = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_idx = 3; m_valid = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            got = {an, seg, dp};
            if (got !== OFF) bad++;
            if (got !== OFF && bad <= 3)
                $display("FAIL reset_idle cycle %0d got %b exp %b", i, got, OFF);
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic test_scan_order();
        logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] exp_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        minutes = 6'd12; seconds = 6'd34; adj = 1'b0; blink_tgl = 1'b0;
        while (m_idx != 3) toggle(7);
        for (int k = 0; k < 4; k++) begin
            toggle(7);
            checks++;
            if ({an, seg, dp} !== {exp_an[k], exp_seg[k], exp_dp[k]}) begin
                errors++;
                $display("FAIL scan_order digit %0d got %b_%b_%b exp %b_%b_%b",
                         k, an, seg, dp, exp_an[k], exp_seg[k], exp_dp[k]);
            end
        end
    endtask

    task automatic test_no_tearing();
        logic [6:0] exp_seg [4] = '{7'b0011001, 7'b0110000, 7'b0010010, 7'b0011001};
        int         step = 0;
        minutes = 6'd12; seconds = 6'd34;
        while (m_idx != 3) toggle(7);
        for (int k = 0; k < 6; k++) begin
            toggle(7);
            if (k == 0) seconds = 6'd45;
            if (k == 0 || k == 1 || k == 4 || k == 5) begin
                checks++;
                if (seg !== exp_seg[step] || an !== ~(4'(1 << m_idx))) begin
                    errors++;
                    $display("FAIL no_tearing step %0d got an=%b seg=%b exp an=%b seg=%b",
                             step, an, seg, ~(4'(1 << m_idx)), exp_seg[step]);
                end
                step++;
            end
        end
    endtask

    task automatic test_blink();
        logic [2:0] cfg [6] = '{3'b101, 3'b100, 3'b001, 3'b111, 3'b110, 3'b011};
        logic [11:0] exp;
        minutes = 6'd12; seconds = 6'd34;
        for (int c = 0; c < 6; c++) begin
            {adj, sel, blink_tgl} = cfg[c];
            for (int k = 0; k < 4; k++) begin
                toggle(7);
                exp = model_out();
                checks++;
                if ({an, seg, dp} !== exp) begin
                    errors++;
                    $display("FAIL blink cfg %b idx %0d got %b exp %b", cfg[c], m_idx, {an, seg, dp}, exp);
                end
            end
        end
        adj = 1'b0; blink_tgl = 1'b0; sel = 1'b0;
    endtask

    task automatic test_clamp();
        logic [6:0] exp_seg [4] = '{7'b0010000, 7'b0010010, 7'b0010000, 7'b0010010};
        minutes = 6'd63; seconds = 6'd60;
        while (m_idx != 3) toggle(7);
        for (int k = 0; k < 4; k++) begin
            toggle(7);
            checks++;
            if (seg !== exp_seg[k]) begin
                errors++;
                $display("FAIL clamp digit %0d got %b exp %b", k, seg, exp_seg[k]);
            end
        end
    endtask

    task automatic test_latency();
        logic [11:0] old_v, new_v;
        minutes = 6'd7; seconds = 6'd18;
        repeat (4) @(negedge clk);
        old_v = model_out();
        @(negedge clk);
        scan_tgl = ~scan_tgl;
        m_idx = (m_idx + 1) % 4;
        if (m_idx == 0) begin
            m_min = clamp(int'(minutes)); m_sec = clamp(int'(seconds)); m_valid = 1;
        end
        new_v = model_out();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== ((k < 4) ? old_v : new_v)) begin
                errors++;
                $display("FAIL latency after edge N+%0d got %b exp %b", k - 1, {an, seg, dp},
                         (k < 4) ? old_v : new_v);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [11:0] exp;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) minutes = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) seconds = 6'($urandom_range(0, 63));
            adj       = 1'($urandom_range(0, 1));
            sel       = 1'($urandom_range(0, 1));
            blink_tgl = 1'($urandom_range(0, 1));
            toggle($urandom_range(5, 9));
            exp = model_out();
            checks++;
            if ({an, seg, dp} !== exp) begin
                errors++;
                $display("FAIL random iter %0d idx %0d got %b exp %b", i, m_idx, {an, seg, dp}, exp);
            end
        end
        adj = 1'b0; blink_tgl = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] exp;
        while (m_idx != 2) toggle(7);
        @(negedge clk);
        rst = 1'b1;
        scan_tgl = 1'b0;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== OFF) begin
            errors++;
            $display("FAIL reset_mid_frame blank got %b exp %b", {an, seg, dp}, OFF);
        end
        @(negedge clk);
        rst = 1'b0;
        m_idx = 3; m_valid = 0;
        repeat (6) @(negedge clk);
        checks++;
        if ({an, seg, dp} !== OFF) begin
            errors++;
            $display("FAIL reset_hold_blank got %b exp %b", {an, seg, dp}, OFF);
        end
        minutes = 6'($urandom_range(0, 59));
        seconds = 6'($urandom_range(0, 59));
        toggle(6);
        exp = model_out();
        checks++;
        if ({an, seg, dp} !== exp || an !== 4'b1110) begin
            errors++;
            $display("FAIL reset_first_digit got %b exp %b", {an, seg, dp}, exp);
        end
    endtask

    initial begin
        rst = 1'b1; scan_tgl = 1'b0; blink_tgl = 1'b0;
        minutes = 6'd0; seconds = 6'd0; adj = 1'b0; sel = 1'b0;
        test_reset();
        test_scan_order();
        test_no_tearing();
        test_blink();
        test_clamp();
        test_latency();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
